// File: rtl/lieat_wbu_pkg.sv
// Shared widths, OITF depth default and packed payload types for the writeback unit.
// Pure declarations; no logic or latency of its own.
// No flow control here; users apply valid/ready on the structs they carry.
package lieat_wbu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_IDX    = 5;
  localparam int RGIDX_NUM  = 1 << REG_IDX;
  localparam int OITF_DEPTH = 4;

  // Dispatch-time fields remembered per OITF entry.
  typedef struct packed {
    logic               en;
    logic [REG_IDX-1:0] rd;
    logic [XLEN-1:0]    pc;
    logic               lsu;
  } oitf_info_t;

  // Writeback fields that hold their value between writeback events.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [REG_IDX-1:0] rd;
    logic [XLEN-1:0]    data;
    logic               lsu;
    logic               ebreak;
  } wb_hold_t;

  // x0 is hardwired, so a write to it is never a real regfile write.
  function automatic logic rd_writes(logic en, logic [REG_IDX-1:0] rd);
    return en & (rd != '0);
  endfunction

endpackage

// File: rtl/lieat_wbu_if.sv
// Bundle of ALU, dispatch, completion, hazard and writeback signals around the WBU.
// Wires only; latency is defined by the modules on either side.
// alu/disp use valid/ready; completions and writeback are fire-and-forget.
interface lieat_wbu_if #(
  parameter int DEPTH = lieat_wbu_pkg::OITF_DEPTH,
  localparam int TAG_W = $clog2(DEPTH)
) ();
  import lieat_wbu_pkg::*;

  logic               alu_valid;
  logic               alu_ready;
  logic [XLEN-1:0]    alu_pc;
  logic               alu_en;
  logic [REG_IDX-1:0] alu_rd;
  logic [XLEN-1:0]    alu_data;
  logic               alu_ebreak;

  logic               disp_valid;
  logic               disp_ready;
  logic [XLEN-1:0]    disp_pc;
  logic               disp_en;
  logic [REG_IDX-1:0] disp_rd;
  logic               disp_lsu;
  logic [TAG_W-1:0]   disp_itag;

  logic               longi_valid;
  logic [TAG_W-1:0]   longi_itag;
  logic [XLEN-1:0]    longi_data;

  logic [REG_IDX-1:0] dep_rs1;
  logic [REG_IDX-1:0] dep_rs2;
  logic [REG_IDX-1:0] dep_rd;
  logic               dep_rs1_hit;
  logic               dep_rs2_hit;
  logic               dep_rd_hit;

  logic               wb_valid;
  logic [XLEN-1:0]    wb_pc;
  logic               wb_en;
  logic [REG_IDX-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               wb_lsu;
  logic               wb_ebreak;
  logic               longi_empty;

  // WBU side.
  modport slave (
    input  alu_valid, alu_pc, alu_en, alu_rd, alu_data, alu_ebreak,
    output alu_ready,
    input  disp_valid, disp_pc, disp_en, disp_rd, disp_lsu,
    output disp_ready, disp_itag,
    input  longi_valid, longi_itag, longi_data,
    input  dep_rs1, dep_rs2, dep_rd,
    output dep_rs1_hit, dep_rs2_hit, dep_rd_hit,
    output wb_valid, wb_pc, wb_en, wb_rd, wb_data, wb_lsu, wb_ebreak, longi_empty
  );

  // EXU / regfile side.
  modport master (
    output alu_valid, alu_pc, alu_en, alu_rd, alu_data, alu_ebreak,
    input  alu_ready,
    output disp_valid, disp_pc, disp_en, disp_rd, disp_lsu,
    input  disp_ready, disp_itag,
    output longi_valid, longi_itag, longi_data,
    output dep_rs1, dep_rs2, dep_rd,
    input  dep_rs1_hit, dep_rs2_hit, dep_rd_hit,
    input  wb_valid, wb_pc, wb_en, wb_rd, wb_data, wb_lsu, wb_ebreak, longi_empty
  );

endinterface

// File: rtl/lieat_general_dff.sv
// Generic reset flop cells: dfflr loads on lden, dffr loads every cycle.
// One cycle from dnxt to qout.
// No flow control; lden is the only qualifier.
module lieat_general_dfflr #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  // Load-enabled state, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    qout <= '0;
    else if (lden) qout <= dnxt;
  end
endmodule

module lieat_general_dffr #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  // Free-running state, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) qout <= '0;
    else        qout <= dnxt;
  end
endmodule

// File: rtl/lieat_wbu_oitf.sv
// Outstanding-long-instruction table: in-order allocate/retire, out-of-order completion, hazard compare.
// Completion marks done at the next edge; head retires the edge after its done flag is registered.
// Dispatch blocked while full (no same-cycle reuse of a retiring slot); retire is never stalled.
module lieat_wbu_oitf import lieat_wbu_pkg::*; #(
  parameter int DEPTH = OITF_DEPTH,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               disp_fire,
  input  oitf_info_t         disp_info,
  output logic [TAG_W-1:0]   disp_itag,
  output logic               full,
  output logic               empty,
  input  logic               cpl_valid,
  input  logic [TAG_W-1:0]   cpl_itag,
  input  logic [XLEN-1:0]    cpl_data,
  output logic               head_rdy,
  output oitf_info_t         head_info,
  output logic [XLEN-1:0]    head_data,
  input  logic [REG_IDX-1:0] dep_rs1,
  input  logic [REG_IDX-1:0] dep_rs2,
  input  logic [REG_IDX-1:0] dep_rd,
  output logic               dep_rs1_hit,
  output logic               dep_rs2_hit,
  output logic               dep_rd_hit
);

  logic [TAG_W:0]     alloc_ptr, ret_ptr;
  logic [TAG_W-1:0]   alloc_idx, ret_idx;
  logic [DEPTH-1:0]   vld_q, done_q;
  logic [DEPTH-1:0]   rs1_vec, rs2_vec, rd_vec;
  oitf_info_t         info_q [DEPTH];
  logic [XLEN-1:0]    data_q [DEPTH];

  assign alloc_idx = alloc_ptr[TAG_W-1:0];
  assign ret_idx   = ret_ptr[TAG_W-1:0];
  assign disp_itag = alloc_idx;

  // Extra wrap bit distinguishes full from empty when the indices meet.
  assign empty = (alloc_ptr == ret_ptr);
  assign full  = ((alloc_ptr ^ ret_ptr) == {1'b1, {TAG_W{1'b0}}});

  assign head_rdy  = vld_q[ret_idx] & done_q[ret_idx];
  assign head_info = info_q[ret_idx];
  assign head_data = data_q[ret_idx];

  lieat_general_dfflr #(.DW(TAG_W+1)) u_alloc_ptr (
    .clock(clock), .reset(reset), .lden(disp_fire),
    .dnxt(alloc_ptr + (TAG_W+1)'(1)), .qout(alloc_ptr)
  );

  lieat_general_dfflr #(.DW(TAG_W+1)) u_ret_ptr (
    .clock(clock), .reset(reset), .lden(head_rdy),
    .dnxt(ret_ptr + (TAG_W+1)'(1)), .qout(ret_ptr)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic set_i, clr_i, cpl_i;

    // Allocation only targets a free slot and retire only a done slot, so the
    // three events are mutually exclusive per entry.
    assign set_i = disp_fire & (alloc_idx == TAG_W'(i));
    assign clr_i = head_rdy & (ret_idx == TAG_W'(i));
    assign cpl_i = cpl_valid & (cpl_itag == TAG_W'(i)) & vld_q[i] & ~done_q[i];

    lieat_general_dfflr #(.DW(1)) u_vld (
      .clock(clock), .reset(reset), .lden(set_i | clr_i),
      .dnxt(set_i), .qout(vld_q[i])
    );

    lieat_general_dfflr #(.DW(1)) u_done (
      .clock(clock), .reset(reset), .lden(set_i | clr_i | cpl_i),
      .dnxt(cpl_i), .qout(done_q[i])
    );

    lieat_general_dfflr #(.DW($bits(oitf_info_t))) u_info (
      .clock(clock), .reset(reset), .lden(set_i),
      .dnxt(disp_info), .qout(info_q[i])
    );

    lieat_general_dfflr #(.DW(XLEN)) u_data (
      .clock(clock), .reset(reset), .lden(cpl_i),
      .dnxt(cpl_data), .qout(data_q[i])
    );

    assign rs1_vec[i] = vld_q[i] & info_q[i].en & (info_q[i].rd == dep_rs1);
    assign rs2_vec[i] = vld_q[i] & info_q[i].en & (info_q[i].rd == dep_rs2);
    assign rd_vec[i]  = vld_q[i] & info_q[i].en & (info_q[i].rd == dep_rd);
  end

  // x0 never carries a dependency.
  assign dep_rs1_hit = (|rs1_vec) & (dep_rs1 != '0);
  assign dep_rs2_hit = (|rs2_vec) & (dep_rs2 != '0);
  assign dep_rd_hit  = (|rd_vec)  & (dep_rd  != '0);

  // A completion must name an allocated entry that has not completed yet.
  assert property (@(posedge clock) disable iff (!reset)
    cpl_valid |-> (vld_q[cpl_itag] & ~done_q[cpl_itag]));

endmodule

// File: rtl/lieat_wbu.sv
// Writeback unit: merges ALU results and in-order OITF retires into one registered regfile port.
// wb_* one cycle after the fire/retire edge; long completion to wb_valid is two cycles.
// Long retire wins: alu_ready drops while the OITF head is done; disp_ready drops while full.
module lieat_wbu import lieat_wbu_pkg::*; #(
  parameter int DEPTH = OITF_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  lieat_wbu_if.slave  bus
);

  logic       long_ret, oitf_full, alu_fire, disp_fire, wb_fire;
  logic       wb_en_nxt;
  oitf_info_t disp_info, head_info;
  logic [XLEN-1:0] head_data;
  wb_hold_t   wb_hold_nxt, wb_hold_q;

  assign disp_info = '{en: bus.disp_en, rd: bus.disp_rd, pc: bus.disp_pc, lsu: bus.disp_lsu};

  assign bus.disp_ready = ~oitf_full;
  assign disp_fire      = bus.disp_valid & ~oitf_full;
  assign bus.alu_ready  = ~long_ret;
  assign alu_fire       = bus.alu_valid & ~long_ret;
  assign wb_fire        = long_ret | alu_fire;

  lieat_wbu_oitf #(.DEPTH(DEPTH)) u_oitf (
    .clock       (clock),
    .reset       (reset),
    .disp_fire   (disp_fire),
    .disp_info   (disp_info),
    .disp_itag   (bus.disp_itag),
    .full        (oitf_full),
    .empty       (bus.longi_empty),
    .cpl_valid   (bus.longi_valid),
    .cpl_itag    (bus.longi_itag),
    .cpl_data    (bus.longi_data),
    .head_rdy    (long_ret),
    .head_info   (head_info),
    .head_data   (head_data),
    .dep_rs1     (bus.dep_rs1),
    .dep_rs2     (bus.dep_rs2),
    .dep_rd      (bus.dep_rd),
    .dep_rs1_hit (bus.dep_rs1_hit),
    .dep_rs2_hit (bus.dep_rs2_hit),
    .dep_rd_hit  (bus.dep_rd_hit)
  );

  // Select the writeback source; fields hold when nothing fires.
  always_comb begin
    wb_hold_nxt = wb_hold_q;
    wb_en_nxt   = 1'b0;
    if (long_ret) begin
      wb_hold_nxt = '{pc: head_info.pc, rd: head_info.rd, data: head_data,
                      lsu: head_info.lsu, ebreak: 1'b0};
      wb_en_nxt   = rd_writes(head_info.en, head_info.rd);
    end else if (alu_fire) begin
      wb_hold_nxt = '{pc: bus.alu_pc, rd: bus.alu_rd, data: bus.alu_data,
                      lsu: 1'b0, ebreak: bus.alu_ebreak};
      wb_en_nxt   = rd_writes(bus.alu_en, bus.alu_rd);
    end
  end

  lieat_general_dffr #(.DW(1)) u_wb_valid (
    .clock(clock), .reset(reset), .dnxt(wb_fire), .qout(bus.wb_valid)
  );

  lieat_general_dffr #(.DW(1)) u_wb_en (
    .clock(clock), .reset(reset), .dnxt(wb_en_nxt), .qout(bus.wb_en)
  );

  lieat_general_dfflr #(.DW($bits(wb_hold_t))) u_wb_hold (
    .clock(clock), .reset(reset), .lden(wb_fire), .dnxt(wb_hold_nxt), .qout(wb_hold_q)
  );

  assign bus.wb_pc     = wb_hold_q.pc;
  assign bus.wb_rd     = wb_hold_q.rd;
  assign bus.wb_data   = wb_hold_q.data;
  assign bus.wb_lsu    = wb_hold_q.lsu;
  assign bus.wb_ebreak = wb_hold_q.ebreak;

endmodule

// File: doc/lieat_wbu.md
Name: lieat_wbu

Overview:
- Writeback unit directly upstream of the register file.
- Merges two result sources into the single registered writeback port the regfile consumes (`wb_*`, `longi_empty`):
  - single-cycle ALU results;
  - long-latency results (LSU, MUL/DIV), which may complete out of order.
- Holds an outstanding-long-instruction table (OITF). The OITF:
  - retires long results in dispatch order;
  - provides RAW/WAW hazard hits to EXU;
  - drives `longi_empty` for difftest.

Parameters:
- DEPTH, 4, OITF entries; power of two, ≥2.
- XLEN, 32, data/pc width.
- REG_IDX, 5, register index width.
- TAG_W, log2(DEPTH), itag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_pc  in  XLEN  ALU instruction pc.
- alu_en  in  1  ALU writes rd.
- alu_rd  in  REG_IDX  ALU destination.
- alu_data  in  XLEN  ALU result.
- alu_ebreak  in  1  instruction is ebreak.
- disp_valid  in  1  long instruction dispatch request.
- disp_ready  out  1  OITF not full.
- disp_pc  in  XLEN  long instruction pc.
- disp_en  in  1  long instruction writes rd.
- disp_rd  in  REG_IDX  long destination.
- disp_lsu  in  1  long instruction is a load/store.
- disp_itag  out  TAG_W  allocated entry index, valid on disp fire.
- longi_valid  in  1  long completion.
- longi_itag  in  TAG_W  completing entry.
- longi_data  in  XLEN  completion data.
- dep_rs1, dep_rs2, dep_rd  in  REG_IDX  EXU hazard query indices.
- dep_rs1_hit, dep_rs2_hit, dep_rd_hit  out  1  pending OITF entry with en=1 matches; index 0 never hits.
- wb_valid  out  1  writeback event.
- wb_pc  out  XLEN  writeback pc.
- wb_en  out  1  regfile write enable.
- wb_rd  out  REG_IDX  writeback destination.
- wb_data  out  XLEN  writeback data.
- wb_lsu  out  1  writeback from LSU.
- wb_ebreak  out  1  ebreak retiring.
- longi_empty  out  1  OITF empty.

Behaviour:
- **OITF structure**
  - Circular buffer with alloc_ptr and ret_ptr, each TAG_W+1 bits (extra wrap bit).
  - Empty when pointers are fully equal; full when indices are equal and wrap bits differ.
  - Per-entry fields: vld, done, en, rd, pc, lsu, data.
- **Dispatch**
  - `disp_ready = ~full`; no same-cycle bypass of a retire.
  - Dispatch fires on `disp_valid & disp_ready`.
  - On fire: `disp_itag = alloc_ptr` index; entry written with vld=1, done=0; alloc_ptr++ (wraps, wrap bit toggles).
- **Completion**
  - `longi_valid` sets done and captures data for entry `longi_itag` at the next edge.
  - Completion to an entry with vld=0 or done=1 is ignored (simulation assertion fires).
  - Completions may arrive in any order.
- **Long retire**
  - `long_ret = head.vld & head.done`, evaluated on registered state.
  - A completion on the head entry therefore retires one cycle later.
  - Completion → `wb_valid` latency is 2 cycles.
  - On retire: head vld cleared; ret_ptr++.
- **Arbitration**
  - Long retire has priority.
  - `alu_ready = ~long_ret`. ALU fires on `alu_valid & alu_ready`.
  - EXU guarantees ALU rd ordering via `dep_*_hit`; the WBU does no ordering check.
- **Output register**
  - All `wb_*` outputs are registered; 1 cycle after the fire/retire edge.
  - `wb_valid` = any fire.
  - `wb_lsu` = head.lsu on a long retire, 0 for ALU.
  - `wb_ebreak` = alu_ebreak on an ALU fire, 0 for long.
  - `wb_en` forced to 0 when rd==0.
  - Without a fire: `wb_valid` = 0 and `wb_en` = 0; other `wb_*` hold their previous values.
- **`longi_empty`**: combinational from registered pointers (empty compare).
- **`dep_*_hit`**: combinational OR over entries with `vld & en & (rd==q) & (q!=0)`.
- **Simultaneous events**
  - Dispatch, completion and retire in the same cycle are all legal.
  - Full + retire: `disp_ready` stays 0 that cycle.
  - Empty + dispatch: `longi_empty` deasserts next cycle.
- **Reset** (asynchronous, active-low)
  - Pointers = 0; all vld/done = 0; all `wb_*` = 0; `longi_empty` = 1.
  - Reset mid-operation discards all entries; no writeback after deassert.

Decomposition:
- Shared package: `XLEN`, `REG_IDX`, `RGIDX_NUM`, OITF DEPTH default, entry field widths.
- Sub-module `lieat_wbu_oitf` holds pointers, entry storage, the hazard compare and the empty/full logic.
- The top level holds the arbiter and output register.
- Flops use the existing `lieat_general_dfflr`/`dffr` cells.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 → next cycle `wb_valid`=1, `wb_en`=1, `wb_rd`=5, `wb_data`=0x1234; `longi_empty`=1 throughout.
- Out-of-order long: dispatch A (itag0, rd=3) then B (itag1, rd=4); complete B=0xB, then A=0xA → `wb_rd` 3/0xA, then 4/0xB, one per cycle; `longi_empty` returns to 1.
- Full: DEPTH=4 dispatches without completion → `disp_ready`=0; 5th request held; complete+retire itag0 → `disp_ready`=1 the cycle after the retire; `disp_itag`=0 (wrap).
- Conflict: head done while alu_valid=1 → `alu_ready`=0 that cycle; long result written first, ALU result next cycle.
- Hazard/rd0: pending entry rd=7 → `dep_rs1_hit`=1 for rs1=7; dispatch rd=0 with en=1 → no hit; its retire has `wb_en`=0.
- Reset mid-flight: 2 entries pending, assert reset → `longi_empty`=1, `wb_valid`=0; later completions ignored.
